// File: rtl/screen_pkg.sv
// Shared definitions for the game display path: screen state encodings,
// the blank pixel value and the state-indexed pixel selection.
package screen_pkg;

  typedef logic [3:0] screen_state_t;

  localparam screen_state_t ST_IDLE  = 4'b0000;
  localparam screen_state_t ST_TITLE = 4'b0001;
  localparam screen_state_t ST_PLAY  = 4'b0010;
  localparam screen_state_t ST_OVER  = 4'b1111;

  localparam int unsigned  PIXEL_W     = 12;
  localparam logic [11:0]  BLANK_PIXEL = 12'h000;

  // Unknown encodings fall through to blank so a corrupted state never shows garbage.
  function automatic logic [11:0] select_pixel(
    input screen_state_t st,
    input logic [11:0]   title_px,
    input logic [11:0]   play_px,
    input logic [11:0]   over_px
  );
    logic [11:0] px;
    case (st)
      ST_TITLE: px = title_px;
      ST_PLAY:  px = play_px;
      ST_OVER:  px = over_px;
      ST_IDLE:  px = BLANK_PIXEL;
      default:  px = BLANK_PIXEL;
    endcase
    return px;
  endfunction

endpackage

// File: rtl/screen_watchdog.sv
// Dwell counter for the game-over screen: counts enabled cycles, holds at its
// terminal count and emits a single expiry pulse until cleared.
module screen_watchdog
  import screen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          fired_q, fired_d;
  logic          at_last;

  assign at_last = (count_q == LAST);

  // The count holds at LAST, so fired_q keeps the pulse to a single cycle.
  assign expired_o = enable_i & ~clear_i & at_last & ~fired_q;

  always_comb begin
    count_d = count_q;
    fired_d = fired_q;
    if (clear_i) begin
      count_d = '0;
      fired_d = 1'b0;
    end else if (enable_i) begin
      if (!at_last) begin
        count_d = count_q + CW'(1);
      end else begin
        fired_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      fired_q <= 1'b0;
    end else begin
      count_q <= count_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Game-level screen controller: frame-synchronous state FSM with a one-deep
// pending request, game-over watchdog, round counter and registered pixel mux.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        dead_in,
  input  logic [2:0]  finished_in,
  input  logic [11:0] title_pixel_in,
  input  logic [11:0] play_pixel_in,
  input  logic [11:0] over_pixel_in,
  output logic [3:0]  state_out,
  output logic [11:0] pixel_out,
  output logic        frame_start_out,
  output logic        timeout_out,
  output logic [7:0]  round_count_out
);

  screen_state_t state_q, state_d;
  logic          pend_valid_q, pend_valid_d;
  screen_state_t pend_tgt_q, pend_tgt_d;
  logic [11:0]   pixel_q, pixel_d;
  logic          frame_start_q;
  logic          timeout_q, timeout_d;
  logic [7:0]    round_q, round_d;

  logic          boundary;
  logic          commit;
  logic          in_over;
  logic          wd_expired;
  logic          req_valid;
  logic          wd_timeout;
  screen_state_t req_tgt;

  assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign commit   = boundary & pend_valid_q;
  assign in_over  = (state_q == ST_OVER);

  screen_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (in_over),
    .clear_i   (~in_over),
    .expired_o (wd_expired)
  );

  // A corrupted state requests IDLE so the machine recovers at the next frame.
  always_comb begin
    req_valid  = 1'b0;
    req_tgt    = state_q;
    wd_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_valid = 1'b1;
        req_tgt   = ST_TITLE;
      end
      ST_TITLE: begin
        if (start_in || finished_in[0]) begin
          req_valid = 1'b1;
          req_tgt   = ST_PLAY;
        end else begin
          req_valid = 1'b0;
        end
      end
      ST_PLAY: begin
        if (dead_in || finished_in[1]) begin
          req_valid = 1'b1;
          req_tgt   = ST_OVER;
        end else begin
          req_valid = 1'b0;
        end
      end
      ST_OVER: begin
        if (finished_in[2]) begin
          req_valid = 1'b1;
          req_tgt   = ST_TITLE;
        end else if (wd_expired && !pend_valid_q) begin
          req_valid  = 1'b1;
          req_tgt    = ST_TITLE;
          wd_timeout = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
      default: begin
        req_valid = 1'b1;
        req_tgt   = ST_IDLE;
      end
    endcase
  end

  // Requests that would only re-select the state being committed are dropped,
  // otherwise they would lock out genuine requests for a whole frame.
  always_comb begin
    state_d      = commit ? pend_tgt_q : state_q;
    pend_valid_d = pend_valid_q & ~commit;
    pend_tgt_d   = pend_tgt_q;
    if (req_valid && (!pend_valid_q || commit) && (req_tgt != state_d)) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = req_tgt;
    end else begin
      pend_tgt_d   = pend_tgt_q;
    end
    if (commit && (state_q == ST_OVER) && (pend_tgt_q == ST_TITLE) && (round_q != 8'hFF)) begin
      round_d = round_q + 8'd1;
    end else begin
      round_d = round_q;
    end
    pixel_d   = select_pixel(state_q, title_pixel_in, play_pixel_in, over_pixel_in);
    timeout_d = wd_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pend_valid_q  <= 1'b0;
      pend_tgt_q    <= ST_IDLE;
      pixel_q       <= BLANK_PIXEL;
      frame_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      round_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_tgt_q    <= pend_tgt_d;
      pixel_q       <= pixel_d;
      frame_start_q <= boundary;
      timeout_q     <= timeout_d;
      round_q       <= round_d;
    end
  end

  assign state_out       = state_q;
  assign pixel_out       = pixel_q;
  assign frame_start_out = frame_start_q;
  assign timeout_out     = timeout_q;
  assign round_count_out = round_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer on an 8x4 frame with a 100-cycle
// game-over timeout: vector table, directed corner cases and a random phase.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int unsigned TO = 100;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int FRAME = FW * FH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        start_in = 1'b0;
  logic        dead_in = 1'b0;
  logic [2:0]  finished_in = '0;
  logic [11:0] title_pixel_in = '0;
  logic [11:0] play_pixel_in = '0;
  logic [11:0] over_pixel_in = '0;
  logic [3:0]  state_out;
  logic [11:0] pixel_out;
  logic        frame_start_out;
  logic        timeout_out;
  logic [7:0]  round_count_out;

  screen_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .start_in        (start_in),
    .dead_in         (dead_in),
    .finished_in     (finished_in),
    .title_pixel_in  (title_pixel_in),
    .play_pixel_in   (play_pixel_in),
    .over_pixel_in   (over_pixel_in),
    .state_out       (state_out),
    .pixel_out       (pixel_out),
    .frame_start_out (frame_start_out),
    .timeout_out     (timeout_out),
    .round_count_out (round_count_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pos = 5;
  bit fix_play = 1'b0;

  // Reference model: game phase, queued request, cycles spent in game over.
  screen_state_t m_state;
  screen_state_t m_pend[$];
  int            m_over_cycles;
  int            m_rounds;
  logic [11:0]   m_pix;
  bit            m_fs;
  bit            m_to;

  typedef struct {
    bit          st;
    bit          dd;
    logic [2:0]  fin;
    logic [3:0]  exp_mid;
    logic [3:0]  exp_after;
    int          exp_rounds;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, pos);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_pend.delete();
    m_over_cycles = 0;
    m_rounds = 0;
    m_pix = 12'h000;
    m_fs = 1'b0;
    m_to = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit dd, input logic [2:0] fin);
    bit boundary;
    bit req;
    bit to;
    screen_state_t tgt;
    screen_state_t nxt;
    boundary = (pos == 0);
    req = 1'b0;
    to = 1'b0;
    tgt = m_state;
    case (m_state)
      ST_IDLE:  begin req = 1'b1; tgt = ST_TITLE; end
      ST_TITLE: if (st || fin[0]) begin req = 1'b1; tgt = ST_PLAY; end
      ST_PLAY:  if (dd || fin[1]) begin req = 1'b1; tgt = ST_OVER; end
      ST_OVER: begin
        if (fin[2]) begin
          req = 1'b1; tgt = ST_TITLE;
        end else if (m_over_cycles == int'(TO) - 1 && m_pend.size() == 0) begin
          req = 1'b1; tgt = ST_TITLE; to = 1'b1;
        end
      end
      default: ;
    endcase
    nxt = m_state;
    if (boundary && m_pend.size() > 0) begin
      nxt = m_pend.pop_front();
      if (m_state == ST_OVER && nxt == ST_TITLE && m_rounds < 255) m_rounds++;
    end
    if (req && m_pend.size() == 0 && tgt != nxt) m_pend.push_back(tgt);
    if (m_state == ST_TITLE)     m_pix = title_pixel_in;
    else if (m_state == ST_PLAY) m_pix = play_pixel_in;
    else if (m_state == ST_OVER) m_pix = over_pixel_in;
    else                         m_pix = 12'h000;
    m_over_cycles = (nxt == ST_OVER && m_state == ST_OVER) ? m_over_cycles + 1 : 0;
    m_fs = boundary;
    m_to = to;
    m_state = nxt;
  endtask

  task automatic cyc(input bit st, input bit dd, input logic [2:0] fin);
    hcount_in = 11'(pos % FW);
    vcount_in = 10'(pos / FW);
    start_in = st;
    dead_in = dd;
    finished_in = fin;
    title_pixel_in = 12'($urandom);
    play_pixel_in = fix_play ? 12'h0F0 : 12'($urandom);
    over_pixel_in = 12'($urandom);
    model_step(st, dd, fin);
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
    check("state", state_out, m_state);
    check("pixel", pixel_out, m_pix);
    check("frame_start", frame_start_out, m_fs);
    check("timeout", timeout_out, m_to);
    check("rounds", round_count_out, m_rounds);
  endtask

  task automatic reset_now(input int ncycles);
    hcount_in = 11'(pos % FW);
    vcount_in = 10'(pos / FW);
    start_in = 1'b0;
    dead_in = 1'b0;
    finished_in = '0;
    rst = 1'b1;
    #1;
    check("rst_state", state_out, ST_IDLE);
    check("rst_pixel", pixel_out, 12'h000);
    check("rst_frame_start", frame_start_out, 1'b0);
    check("rst_timeout", timeout_out, 1'b0);
    check("rst_rounds", round_count_out, 8'd0);
    model_reset();
    for (int i = 0; i < ncycles; i++) begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % FRAME;
      hcount_in = 11'(pos % FW);
      vcount_in = 10'(pos / FW);
    end
    rst = 1'b0;
  endtask

  task automatic align(input int p);
    while (pos != p) cyc(1'b0, 1'b0, 3'b000);
  endtask

  // Runs one frame from pos 1, pulsing the event at pos 2; mid is the state just before the boundary.
  task automatic frame(input bit st, input bit dd, input logic [2:0] fin, output logic [3:0] mid);
    align(1);
    mid = '0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(pos == 2 ? st : 1'b0, pos == 2 ? dd : 1'b0, pos == 2 ? fin : 3'b000);
      if (i == FRAME - 2) mid = state_out;
    end
  endtask

  task automatic idle_to_title();
    while (pos != 0) begin
      cyc(1'b0, 1'b0, 3'b000);
      check("idle_state", state_out, ST_IDLE);
      check("idle_pixel", pixel_out, 12'h000);
    end
    cyc(1'b0, 1'b0, 3'b000);
    check("title_after_boundary", state_out, ST_TITLE);
    check("frame_start_on_commit", frame_start_out, 1'b1);
  endtask

  initial begin
    logic [3:0] mid;
    int to_count;
    int to_at;
    vecs[0] = '{1'b0, 1'b1, 3'b000, ST_TITLE, ST_TITLE, 0};
    vecs[1] = '{1'b0, 1'b0, 3'b010, ST_TITLE, ST_TITLE, 0};
    vecs[2] = '{1'b1, 1'b0, 3'b000, ST_TITLE, ST_PLAY,  0};
    vecs[3] = '{1'b1, 1'b0, 3'b000, ST_PLAY,  ST_PLAY,  0};
    vecs[4] = '{1'b0, 1'b0, 3'b010, ST_PLAY,  ST_OVER,  0};
    vecs[5] = '{1'b1, 1'b1, 3'b011, ST_OVER,  ST_OVER,  0};
    vecs[6] = '{1'b0, 1'b0, 3'b100, ST_OVER,  ST_TITLE, 1};
    vecs[7] = '{1'b0, 1'b0, 3'b001, ST_TITLE, ST_PLAY,  1};
    vecs[8] = '{1'b1, 1'b1, 3'b000, ST_PLAY,  ST_OVER,  1};
    vecs[9] = '{1'b0, 1'b0, 3'b100, ST_OVER,  ST_TITLE, 2};

    model_reset();
    @(posedge clk);
    #1;
    reset_now(3);
    idle_to_title();

    foreach (vecs[k]) begin
      frame(vecs[k].st, vecs[k].dd, vecs[k].fin, mid);
      check($sformatf("vec%0d_mid", k), mid, vecs[k].exp_mid);
      check($sformatf("vec%0d_after", k), state_out, vecs[k].exp_after);
      check($sformatf("vec%0d_rounds", k), round_count_out, vecs[k].exp_rounds);
    end

    // Start mid-frame in TITLE: commit waits for the boundary, pixel two cycles after it.
    fix_play = 1'b1;
    align(3);
    cyc(1'b1, 1'b0, 3'b000);
    while (pos != 0) begin
      cyc(1'b0, 1'b0, 3'b000);
      check("title_holds", state_out, ST_TITLE);
    end
    cyc(1'b0, 1'b0, 3'b000);
    check("play_commit", state_out, ST_PLAY);
    cyc(1'b0, 1'b0, 3'b000);
    check("play_pixel_latency", pixel_out, 12'h0F0);
    fix_play = 1'b0;

    // Watchdog expiry with no finished pulse.
    frame(1'b0, 1'b1, 3'b000, mid);
    check("over_entered", state_out, ST_OVER);
    to_count = 0;
    to_at = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1'b0, 1'b0, 3'b000);
      if (timeout_out === 1'b1) begin
        to_count++;
        if (to_at < 0) to_at = i;
      end
      if (state_out != ST_OVER) break;
    end
    check("timeout_pulses", to_count, 1);
    check("timeout_cycle", to_at, 100);
    check("timeout_exit_state", state_out, ST_TITLE);
    check("timeout_rounds", round_count_out, 8'd3);

    // Finished pulse on the expiry cycle wins over the watchdog.
    frame(1'b1, 1'b0, 3'b000, mid);
    frame(1'b0, 1'b1, 3'b000, mid);
    check("over_entered2", state_out, ST_OVER);
    to_count = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1'b0, 1'b0, i == 100 ? 3'b100 : 3'b000);
      if (timeout_out === 1'b1) to_count++;
      if (state_out != ST_OVER) break;
    end
    check("fin_on_expiry_no_timeout", to_count, 0);
    check("fin_on_expiry_state", state_out, ST_TITLE);
    check("fin_on_expiry_rounds", round_count_out, 8'd4);

    // Random events against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
          3'($urandom_range(0, 7) & {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0}));
    end

    // Reset in the middle of game over.
    for (int f = 0; f < 10 && state_out != ST_OVER; f++) begin
      if (state_out == ST_TITLE)     frame(1'b1, 1'b0, 3'b000, mid);
      else if (state_out == ST_PLAY) frame(1'b0, 1'b1, 3'b000, mid);
      else                           frame(1'b0, 1'b0, 3'b000, mid);
    end
    check("pre_reset_over", state_out, ST_OVER);
    align(3);
    reset_now(2);
    idle_to_title();
    check("post_reset_rounds", round_count_out, 8'd0);

    // Round counter saturation.
    for (int g = 0; g < 260; g++) begin
      frame(1'b1, 1'b0, 3'b000, mid);
      frame(1'b0, 1'b1, 3'b000, mid);
      frame(1'b0, 1'b0, 3'b100, mid);
      if (g == 254) check("rounds_at_255", round_count_out, 8'd255);
    end
    check("rounds_saturated", round_count_out, 8'd255);
    check("final_state", state_out, ST_TITLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the game display path. Owns the game-level FSM (idle → title → play → game over → title) and drives the 4-bit `state_in` bus that each screen module watches. Consumes the screen modules' `finished` pulses and registers their 12-bit pixel streams through a mux to the VGA output. State changes commit only at a frame boundary, so a screen never switches mid-frame.

## Interface

- `TIMEOUT_CYCLES`, default 130_000_000: maximum game-over dwell (2 s at 65 MHz) before a forced return to title.
- `clk` in 1: pixel clock; the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `hcount_in` in 11: current pixel column.
- `vcount_in` in 10: current pixel row.
- `start_in` in 1: one-cycle pulse from the debounced start button.
- `dead_in` in 1: level from game logic; player has died.
- `finished_in` in 3: one-cycle finished pulses, one bit per screen: [0] title, [1] play, [2] game over.
- `title_pixel_in`, `play_pixel_in`, `over_pixel_in` in 12 each: pixel outputs of the screen modules.
- `state_out` out 4: committed game state, broadcast to the screen modules.
- `pixel_out` out 12: registered selected pixel.
- `frame_start_out` out 1: one-cycle pulse on each frame boundary.
- `timeout_out` out 1: one-cycle pulse when the watchdog forces game over to exit.
- `round_count_out` out 8: completed games; saturates at 255.

## Operation

- State encodings: IDLE = 4'b0000, TITLE = 4'b0001, PLAY = 4'b0010, OVER = 4'b1111.
- Frame boundary: the cycle where `hcount_in == 0 && vcount_in == 0`.
- Transition requests are captured into a `pending` register (valid bit plus target state). The request is committed to `state_out` on the next frame boundary, and `pending` clears on commit.
- IDLE: unconditional request to TITLE. All inputs are ignored.
- TITLE: `start_in` or `finished_in[0]` requests PLAY.
- PLAY: `dead_in` high or `finished_in[1]` requests OVER. `start_in` is ignored.
- OVER: `finished_in[2]` or watchdog expiry requests TITLE. `round_count_out` increments (saturating) on the commit of OVER→TITLE.
- Pending handling:
  - First request wins while `pending` is valid; later events are dropped until commit.
  - A request arriving on the boundary cycle itself is captured and waits for the next boundary.
- Watchdog:
  - Counts cycles while `state_out == OVER`; cleared on any other state.
  - When the count reaches `TIMEOUT_CYCLES-1` with no pending request, it raises a pending TITLE request and pulses `timeout_out` for one cycle.
  - If `finished_in[2]` arrives on the same cycle, it takes priority and `timeout_out` stays 0.
- Pixel mux by `state_out`: TITLE→title, PLAY→play, OVER→over, IDLE→12'h000. Any unknown state also outputs 12'h000.

## Timing

- Reset values: `state_out` = IDLE, `pixel_out` = 0, `frame_start_out` = 0, `timeout_out` = 0, `round_count_out` = 0. `pending` and the watchdog are cleared.
- Reset mid-frame or mid-OVER aborts immediately; the FSM resumes from IDLE.
- `state_out` updates on the clock edge that samples the boundary cycle, i.e. it is visible one cycle after `hcount_in == 0 && vcount_in == 0`.
- `frame_start_out` is high in the same cycle that `state_out` updates.
- `pixel_out` has a latency of 1 cycle from the `*_pixel_in` inputs and from `state_out`. The first pixel of a new state appears 2 cycles after the boundary sample.
- Request-to-commit latency: at least 1 frame boundary; at most one full frame plus 1 cycle.
- Watchdog width: `$clog2(TIMEOUT_CYCLES)` bits. It does not wrap; it holds at its terminal count until the state leaves OVER.

## Structure

- Shared package `screen_pkg`: state encodings (`ST_IDLE`, `ST_TITLE`, `ST_PLAY`, `ST_OVER`), the `screen_state_t` typedef, and the `BLANK_PIXEL` constant. The existing screen modules import the same package.
- Sub-module `screen_watchdog`: a parameterised cycle counter with `enable`, `clear`, and an `expired` pulse output. It is instantiated once.
- Top level holds the FSM, the `pending` register, the round counter and the pixel mux.

## Test plan

Bench settings: `TIMEOUT_CYCLES` = 100; the bench drives an 8×4 frame (hcount 0–7, vcount 0–3).

- Release reset → `state_out` = 4'b0001 one cycle after the first (0,0); `pixel_out` = 12'h000 while IDLE.
- In TITLE, pulse `start_in` mid-frame with `play_pixel_in` = 12'h0F0 → `state_out` stays 4'b0001 until the next (0,0), then becomes 4'b0010; `pixel_out` = 12'h0F0 two cycles after the boundary.
- In PLAY, raise `dead_in` and pulse `start_in` on the same cycle → next boundary commits 4'b1111; `start_in` has no effect.
- In OVER, never assert `finished_in[2]` → `timeout_out` pulses exactly once, 100 cycles after entry; `state_out` = 4'b0001 at the following boundary; `round_count_out` = 1.
- In OVER, assert `finished_in[2]` on the watchdog's expiry cycle → `timeout_out` stays 0; the return to TITLE still happens; the round count increments.
- Assert `rst` mid-OVER at hcount = 3 → all outputs are 0 / IDLE immediately, before the next clock edge. Complete 256 games → `round_count_out` holds at 255.
